// File: rtl/debug_serializer_pkg.sv
// Shared types and constants for the debug byte serializer.
package debug_serializer_pkg;

   localparam int unsigned DEF_LEN      = 32;
   localparam int unsigned DEF_CANT_REG = 16;
   localparam int unsigned DEF_CANT_MEM = 8;
   localparam int unsigned DEF_NBITS    = 8;
   localparam int unsigned DEF_NB_LATCH = 480;

   localparam int unsigned BYTES_WORD  = DEF_LEN / DEF_NBITS;
   localparam int unsigned BYTES_LATCH = DEF_NB_LATCH / DEF_NBITS;

   // Bit positions inside the section-select mask
   localparam int unsigned SEL_LATCH = 0;
   localparam int unsigned SEL_REG   = 1;
   localparam int unsigned SEL_MEM   = 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FETCH = 3'd2,
      S_SEND  = 3'd3,
      S_WAIT  = 3'd4,
      S_NEXT  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      SEC_LATCH = 2'd0,
      SEC_REG   = 2'd1,
      SEC_MEM   = 2'd2
   } sec_t;

   // Byte counter must hold the full byte count of the longest section
   function automatic int unsigned cnt_width(input int unsigned bw, input int unsigned bl);
      return $clog2((bw > bl) ? bw : bl) + 1;
   endfunction

endpackage

// File: rtl/debug_serializer_byte_shifter.sv
// Loadable right-shift register that exposes its low byte.
module byte_shifter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NBITS = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_shift,
   output logic [NBITS-1:0] o_low
);

   logic [WIDTH-1:0] r_q;

   // Load has priority over shift; shift drops the byte just sent
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         r_q <= '0;
      else if (i_load)
         r_q <= i_din;
      else if (i_shift)
         r_q <= r_q >> NBITS;
   end

   assign o_low = r_q[NBITS-1:0];

endmodule

// File: rtl/debug_serializer.sv
// Streams a latch snapshot, the register file and data memory as UART bytes.
module debug_serializer
   import debug_serializer_pkg::*;
#(
   parameter int unsigned LEN      = DEF_LEN,
   parameter int unsigned CANT_REG = DEF_CANT_REG,
   parameter int unsigned CANT_MEM = DEF_CANT_MEM,
   parameter int unsigned NBITS    = DEF_NBITS,
   parameter int unsigned NB_LATCH = DEF_NB_LATCH
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_start,
   input  logic [2:0]                  i_sel,
   input  logic [NB_LATCH-1:0]         i_latches,
   input  logic [LEN-1:0]              i_reg,
   input  logic [LEN-1:0]              i_mem_datos,
   input  logic                        i_tx_done,
   output logic [$clog2(CANT_REG)-1:0] o_addr_reg,
   output logic [$clog2(CANT_MEM)-1:0] o_addr_mem,
   output logic [NBITS-1:0]            o_data,
   output logic                        o_tx_start,
   output logic                        o_busy,
   output logic                        o_done
);

   localparam int unsigned AWR = $clog2(CANT_REG);
   localparam int unsigned AWM = $clog2(CANT_MEM);
   localparam int unsigned BW  = LEN / NBITS;
   localparam int unsigned BL  = NB_LATCH / NBITS;
   localparam int unsigned CW  = cnt_width(BW, BL);

   state_t           r_state;
   sec_t             r_sec;
   logic [2:0]       r_sel;
   logic [CW-1:0]    r_cnt;
   logic [AWR-1:0]   r_addr_reg;
   logic [AWM-1:0]   r_addr_mem;
   logic [NBITS-1:0] r_data;
   logic             r_tx_start;
   logic             r_busy;
   logic             r_done;

   logic             w_snap_load;
   logic             w_snap_shift;
   logic             w_word_load;
   logic             w_word_shift;
   logic [LEN-1:0]   w_word_din;
   logic [NBITS-1:0] w_snap_low;
   logic [NBITS-1:0] w_word_low;
   logic             w_addr_last;
   logic             w_has_next;
   sec_t             w_next_sec;

   assign w_snap_load  = (r_state == S_IDLE) && i_start;
   assign w_snap_shift = (r_state == S_WAIT) && i_tx_done && (r_sec == SEC_LATCH);
   assign w_word_load  = (r_state == S_FETCH);
   assign w_word_shift = (r_state == S_WAIT) && i_tx_done && (r_sec != SEC_LATCH);
   assign w_word_din   = (r_sec == SEC_REG) ? i_reg : i_mem_datos;
   assign w_addr_last  = (r_sec == SEC_REG) ? (r_addr_reg == AWR'(CANT_REG - 1))
                                            : (r_addr_mem == AWM'(CANT_MEM - 1));

   byte_shifter #(.WIDTH(NB_LATCH), .NBITS(NBITS)) u_snap (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_snap_load),
      .i_din   (i_latches),
      .i_shift (w_snap_shift),
      .o_low   (w_snap_low)
   );

   byte_shifter #(.WIDTH(LEN), .NBITS(NBITS)) u_word (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_word_load),
      .i_din   (w_word_din),
      .i_shift (w_word_shift),
      .o_low   (w_word_low)
   );

   // Next selected section after the current one, in fixed order latch/reg/mem
   always_comb begin
      w_has_next = 1'b0;
      w_next_sec = SEC_MEM;
      case (r_sec)
         SEC_LATCH: begin
            if (r_sel[SEL_REG]) begin
               w_has_next = 1'b1;
               w_next_sec = SEC_REG;
            end else if (r_sel[SEL_MEM]) begin
               w_has_next = 1'b1;
            end
         end
         SEC_REG:  w_has_next = r_sel[SEL_MEM];
         default:  w_has_next = 1'b0;
      endcase
   end

   // Transfer sequencer with registered outputs
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state    <= S_IDLE;
         r_sec      <= SEC_LATCH;
         r_sel      <= '0;
         r_cnt      <= '0;
         r_addr_reg <= '0;
         r_addr_mem <= '0;
         r_data     <= '0;
         r_tx_start <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_sel      <= i_sel;
                  r_cnt      <= '0;
                  r_addr_reg <= '0;
                  r_addr_mem <= '0;
                  if (i_sel[SEL_LATCH]) begin
                     // Latch bytes come straight from the bus on the snapshot edge
                     r_sec      <= SEC_LATCH;
                     r_data     <= i_latches[NBITS-1:0];
                     r_tx_start <= 1'b1;
                     r_busy     <= 1'b1;
                     r_state    <= S_SEND;
                  end else if (i_sel[SEL_REG]) begin
                     r_sec   <= SEC_REG;
                     r_busy  <= 1'b1;
                     r_state <= S_LOAD;
                  end else if (i_sel[SEL_MEM]) begin
                     r_sec   <= SEC_MEM;
                     r_busy  <= 1'b1;
                     r_state <= S_LOAD;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            S_LOAD: r_state <= S_FETCH;
            S_FETCH: begin
               r_data     <= w_word_din[NBITS-1:0];
               r_tx_start <= 1'b1;
               r_state    <= S_SEND;
            end
            S_SEND: r_state <= S_WAIT;
            S_WAIT: begin
               if (i_tx_done) begin
                  r_cnt   <= r_cnt + CW'(1);
                  r_state <= S_NEXT;
               end
            end
            S_NEXT: begin
               if ((r_sec == SEC_LATCH) && (r_cnt != CW'(BL))) begin
                  r_data     <= w_snap_low;
                  r_tx_start <= 1'b1;
                  r_state    <= S_SEND;
               end else if ((r_sec != SEC_LATCH) && (r_cnt != CW'(BW))) begin
                  r_data     <= w_word_low;
                  r_tx_start <= 1'b1;
                  r_state    <= S_SEND;
               end else if ((r_sec != SEC_LATCH) && !w_addr_last) begin
                  r_cnt <= '0;
                  if (r_sec == SEC_REG)
                     r_addr_reg <= r_addr_reg + AWR'(1);
                  else
                     r_addr_mem <= r_addr_mem + AWM'(1);
                  r_state <= S_LOAD;
               end else if (w_has_next) begin
                  r_cnt   <= '0;
                  r_sec   <= w_next_sec;
                  r_state <= S_LOAD;
               end else begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_addr_reg = r_addr_reg;
   assign o_addr_mem = r_addr_mem;
   assign o_data     = r_data;
   assign o_tx_start = r_tx_start;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule

// File: tb/tb_debug_serializer.sv
// Directed self-checking bench for debug_serializer.
module tb_debug_serializer;
   import debug_serializer_pkg::*;

   logic         i_clk = 1'b0;
   logic         rst_n;
   logic         i_start;
   logic [2:0]   i_sel;
   logic [479:0] i_latches;
   logic [31:0]  i_reg;
   logic [31:0]  i_mem_datos;
   logic         i_tx_done;
   logic [3:0]   o_addr_reg;
   logic [2:0]   o_addr_mem;
   logic [7:0]   o_data;
   logic         o_tx_start;
   logic         o_busy;
   logic         o_done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int nb;
   logic done_seen;
   logic [7:0] got [0:255];
   logic [3:0] ga_reg [0:255];
   logic [2:0] ga_mem [0:255];
   int         tst [0:255];
   logic [479:0] snap;
   int t0;
   logic any_done;

   debug_serializer dut (
      .i_clk       (i_clk),
      .i_rst       (rst_n),
      .i_start     (i_start),
      .i_sel       (i_sel),
      .i_latches   (i_latches),
      .i_reg       (i_reg),
      .i_mem_datos (i_mem_datos),
      .i_tx_done   (i_tx_done),
      .o_addr_reg  (o_addr_reg),
      .o_addr_mem  (o_addr_mem),
      .o_data      (o_data),
      .o_tx_start  (o_tx_start),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Combinational register file / data memory models
   assign i_reg       = 32'h1000_0000 + 32'(o_addr_reg);
   assign i_mem_datos = 32'hC0DE_0000 + 32'(o_addr_mem) * 32'h11;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] bsel(input logic [31:0] w, input int b);
      return w[b*8 +: 8];
   endfunction

   function automatic logic [7:0] reg_byte(input int k, input int b);
      return bsel(32'h1000_0000 + 32'(k), b);
   endfunction

   function automatic logic [7:0] mem_byte(input int k, input int b);
      return bsel(32'hC0DE_0000 + 32'(k) * 32'h11, b);
   endfunction

   task automatic pulse_start(input logic [2:0] sel);
      t0 = cyc;
      i_sel   = sel;
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   // Acts as the UART: acknowledge each byte 'gap' cycles after its start pulse
   task automatic collect(input int gap, input bit spur, input int max_bytes);
      int guard;
      guard = 0;
      nb = 0;
      done_seen = 1'b0;
      while (!done_seen && nb < max_bytes && guard < 20000) begin
         if (o_tx_start === 1'b1) begin
            got[nb] = o_data;
            ga_reg[nb] = o_addr_reg;
            ga_mem[nb] = o_addr_mem;
            tst[nb] = cyc;
            nb++;
            if (spur) begin
               i_start = 1'b1;
               i_tx_done = 1'b1;
               @(negedge i_clk);
               i_start = 1'b0;
               i_tx_done = 1'b0;
               repeat (gap - 1) @(negedge i_clk);
            end else begin
               repeat (gap) @(negedge i_clk);
            end
            i_tx_done = 1'b1;
            @(negedge i_clk);
            i_tx_done = 1'b0;
            guard += gap + 1;
         end else if (o_done === 1'b1) begin
            done_seen = 1'b1;
         end else begin
            @(negedge i_clk);
            guard++;
         end
      end
      if (guard >= 20000) chk("timeout", 64'(0), 64'(1));
   endtask

   initial begin
      rst_n = 1'b0;
      i_start = 1'b0;
      i_sel = 3'b000;
      i_tx_done = 1'b0;
      for (int i = 0; i < 60; i++) i_latches[i*8 +: 8] = 8'(i * 7 + 3);
      repeat (2) @(negedge i_clk);

      // Reset state
      chk("rst_busy", 64'(o_busy), 64'(0));
      chk("rst_done", 64'(o_done), 64'(0));
      chk("rst_txs", 64'(o_tx_start), 64'(0));
      chk("rst_data", 64'(o_data), 64'(0));
      chk("rst_areg", 64'(o_addr_reg), 64'(0));
      chk("rst_amem", 64'(o_addr_mem), 64'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge i_clk);

      // Empty mask: done next cycle, nothing sent, never busy
      pulse_start(3'b000);
      chk("sel0_done", 64'(o_done), 64'(1));
      chk("sel0_busy", 64'(o_busy), 64'(0));
      chk("sel0_txs", 64'(o_tx_start), 64'(0));
      @(negedge i_clk);
      chk("sel0_done_end", 64'(o_done), 64'(0));
      chk("sel0_busy2", 64'(o_busy), 64'(0));
      repeat (2) @(negedge i_clk);

      // Register file only
      pulse_start(3'b010);
      chk("reg_busy", 64'(o_busy), 64'(1));
      collect(5, 1'b0, 256);
      chk("reg_done", 64'(done_seen), 64'(1));
      chk("reg_busy_drop", 64'(o_busy), 64'(0));
      chk("reg_nbytes", 64'(nb), 64'(64));
      chk("reg_lat", 64'(tst[0] - t0), 64'(3));
      chk("reg_b0", 64'(got[0]), 64'(8'h00));
      chk("reg_b3", 64'(got[3]), 64'(8'h10));
      chk("reg_gap_in", 64'(tst[1] - tst[0]), 64'(7));
      chk("reg_gap_x", 64'(tst[4] - tst[3]), 64'(9));
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("reg_addr%0d", k), 64'(ga_reg[4*k]), 64'(k));
         for (int b = 0; b < 4; b++)
            chk($sformatf("reg_byte%0d_%0d", k, b), 64'(got[4*k+b]), 64'(reg_byte(k, b)));
      end
      chk("reg_addr_hold", 64'(o_addr_reg), 64'(15));
      @(negedge i_clk);
      chk("reg_done_pulse", 64'(o_done), 64'(0));
      repeat (2) @(negedge i_clk);

      // All sections; latch bus changes right after the snapshot
      snap = i_latches;
      pulse_start(3'b111);
      i_latches = ~i_latches;
      collect(2, 1'b0, 256);
      chk("all_done", 64'(done_seen), 64'(1));
      chk("all_nbytes", 64'(nb), 64'(BYTES_LATCH + 16 * BYTES_WORD + 8 * BYTES_WORD));
      chk("all_lat", 64'(tst[0] - t0), 64'(1));
      for (int i = 0; i < 60; i++)
         chk($sformatf("all_latch%0d", i), 64'(got[i]), 64'(snap[i*8 +: 8]));
      for (int k = 0; k < 16; k++)
         for (int b = 0; b < 4; b++)
            chk($sformatf("all_reg%0d_%0d", k, b), 64'(got[60+4*k+b]), 64'(reg_byte(k, b)));
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("all_maddr%0d", k), 64'(ga_mem[124+4*k]), 64'(k));
         for (int b = 0; b < 4; b++)
            chk($sformatf("all_mem%0d_%0d", k, b), 64'(got[124+4*k+b]), 64'(mem_byte(k, b)));
      end
      repeat (2) @(negedge i_clk);

      // Spurious start/tx_done in LOAD and in every SEND
      pulse_start(3'b100);
      i_sel = 3'b001;
      i_start = 1'b1;
      i_tx_done = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      i_tx_done = 1'b0;
      collect(3, 1'b1, 256);
      chk("spur_done", 64'(done_seen), 64'(1));
      chk("spur_nbytes", 64'(nb), 64'(32));
      chk("spur_lat", 64'(tst[0] - t0), 64'(3));
      chk("spur_gap_in", 64'(tst[1] - tst[0]), 64'(5));
      for (int k = 0; k < 8; k++)
         for (int b = 0; b < 4; b++)
            chk($sformatf("spur_mem%0d_%0d", k, b), 64'(got[4*k+b]), 64'(mem_byte(k, b)));
      repeat (2) @(negedge i_clk);

      // Reset in the middle of the memory section
      pulse_start(3'b100);
      collect(2, 1'b0, 10);
      chk("mid_nbytes", 64'(nb), 64'(10));
      chk("mid_busy_pre", 64'(o_busy), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(o_busy), 64'(0));
      chk("mid_rst_amem", 64'(o_addr_mem), 64'(0));
      chk("mid_rst_data", 64'(o_data), 64'(0));
      chk("mid_rst_txs", 64'(o_tx_start), 64'(0));
      any_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         if (o_done !== 1'b0) any_done = 1'b1;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         if (o_done !== 1'b0) any_done = 1'b1;
      end
      chk("mid_no_done", 64'(any_done), 64'(0));
      pulse_start(3'b100);
      collect(2, 1'b0, 256);
      chk("re_done", 64'(done_seen), 64'(1));
      chk("re_nbytes", 64'(nb), 64'(32));
      chk("re_addr0", 64'(ga_mem[0]), 64'(0));
      chk("re_addr7", 64'(ga_mem[28]), 64'(7));
      for (int k = 0; k < 8; k++)
         for (int b = 0; b < 4; b++)
            chk($sformatf("re_mem%0d_%0d", k, b), 64'(got[4*k+b]), 64'(mem_byte(k, b)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
